// File: rtl/cpu_run_controller_if.sv
// cpu_run_controller_if
//   Groups the run-control signals between the CPU datapath glue and the run
//   sequencer. The controller attaches through the slave modport. The block
//   that supplies start/step requests and the datapath observations
//   (instruction, pc) attaches through the master modport.
//
//   Requests / observations (master -> slave):
//     start        run request
//     step_mode    1 = single-step, 0 = free-run
//     step_req     request to retire one instruction in step mode
//     instruction  current instruction-memory output
//     pc           current PC register output
//   Controls / status (slave -> master):
//     dp_en, pc_write, step_ack, running, halted, halt_cause,
//     cycle_count, retired_count
interface cpu_run_controller_if;
  logic        start;
  logic        step_mode;
  logic        step_req;
  logic [31:0] instruction;
  logic [63:0] pc;

  logic        dp_en;
  logic        pc_write;
  logic        step_ack;
  logic        running;
  logic        halted;
  logic [1:0]  halt_cause;
  logic [31:0] cycle_count;
  logic [31:0] retired_count;

  modport master (
    output start, step_mode, step_req, instruction, pc,
    input  dp_en, pc_write, step_ack, running, halted, halt_cause,
           cycle_count, retired_count
  );

  modport slave (
    input  start, step_mode, step_req, instruction, pc,
    output dp_en, pc_write, step_ack, running, halted, halt_cause,
           cycle_count, retired_count
  );
endinterface

// File: rtl/cpu_run_controller.sv
// cpu_run_controller
//   Run sequencer for the single-cycle CPU datapath. A start request holds
//   the datapath in reset for RESET_CYCLES cycles, then lets it run with PC
//   updates gated either free-running or one instruction per step request.
//   Execution halts on a halt opcode, a PC at/above PC_LIMIT, or after
//   MAX_CYCLES cycles in RUN. Cycle and retired-instruction counts are kept.
//
//   Ports:
//     Clk    rising-edge clock
//     Reset  asynchronous, active-high reset
//     bus    cpu_run_controller_if.slave (requests in, controls/status out)
//
//   pc_write and step_ack are combinational (they must track the current
//   instruction and pc); every other output comes straight from a flop.
module cpu_run_controller #(
  parameter int unsigned RESET_CYCLES = 2,
  parameter logic [31:0] MAX_CYCLES   = 32'd1024,
  parameter logic [63:0] PC_LIMIT     = 64'h400,
  parameter logic [6:0]  HALT_OPCODE  = 7'b1110011
) (
  input  logic                 Clk,
  input  logic                 Reset,
  cpu_run_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_RESET_HOLD = 2'd1,
    S_RUN        = 2'd2,
    S_HALTED     = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_OPCODE  = 2'd1,
    CAUSE_TIMEOUT = 2'd2,
    CAUSE_PC      = 2'd3
  } cause_e;

  localparam int unsigned       HOLD_W     = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [31:0]       CYCLE_LAST = MAX_CYCLES - 32'd1;

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [31:0]         cycle_q, cycle_d;
  logic [31:0]         retired_q, retired_d;
  cause_e              cause_q, cause_d;
  logic                pending_q, pending_d;
  logic                dp_en_q, running_q, halted_q;

  logic                in_run;
  logic                pc_oor;
  logic                halt_op;
  logic                timeout;
  logic                retire_blocked;
  logic                halt_hit;
  cause_e              hit_cause;
  logic                pc_write;
  logic                step_ack;

  // Only the opcode field of the instruction is decoded here.
  logic                unused_instr_bits;
  assign unused_instr_bits = ^bus.instruction[31:7];

  assign in_run  = (state_q == S_RUN);
  assign pc_oor  = (bus.pc >= PC_LIMIT);
  assign halt_op = (bus.instruction[6:0] == HALT_OPCODE);
  assign timeout = (cycle_q == CYCLE_LAST);

  // A bad PC or halt opcode must never retire; the timeout cycle still may.
  assign retire_blocked = pc_oor | halt_op;
  assign halt_hit       = in_run & (retire_blocked | timeout);

  assign pc_write = in_run & ~retire_blocked & (~bus.step_mode | pending_q);
  // A pending step is consumed by the first retire-capable RUN cycle, even if
  // step_mode dropped to 0 in the meantime.
  assign step_ack = in_run & ~retire_blocked & pending_q;

  always_comb begin
    hit_cause = CAUSE_NONE;
    if (pc_oor)       hit_cause = CAUSE_PC;
    else if (halt_op) hit_cause = CAUSE_OPCODE;
    else if (timeout) hit_cause = CAUSE_TIMEOUT;
  end

  always_comb begin
    // NOTE: every _d starts from its _q so that no branch leaves a value
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    hold_d    = hold_q;
    cycle_d   = cycle_q;
    retired_d = retired_q;
    cause_d   = cause_q;
    pending_d = pending_q;

    unique case (state_q)
      S_IDLE, S_HALTED: begin
        if (bus.start) begin
          state_d   = S_RESET_HOLD;
          hold_d    = '0;
          cycle_d   = '0;
          retired_d = '0;
          cause_d   = CAUSE_NONE;
          pending_d = 1'b0;
        end
      end
      S_RESET_HOLD: begin
        if (hold_q == HOLD_LAST) state_d = S_RUN;
        else                     hold_d  = hold_q + 1'b1;
      end
      S_RUN: begin
        if (pc_write) retired_d = retired_q + 32'd1;
        if (halt_hit) begin
          state_d   = S_HALTED;
          cause_d   = hit_cause;
          pending_d = 1'b0;
        end else begin
          // The halting cycle is not counted, so a timeout leaves
          // cycle_count at MAX_CYCLES-1.
          cycle_d = cycle_q + 32'd1;
          // A request arriving while one is pending merges into it.
          if (step_ack)                         pending_d = 1'b0;
          else if (bus.step_mode & bus.step_req) pending_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      hold_q    <= '0;
      cycle_q   <= '0;
      retired_q <= '0;
      cause_q   <= CAUSE_NONE;
      pending_q <= 1'b0;
      dp_en_q   <= 1'b0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values of
      // the previous cycle regardless of statement order.
      state_q   <= state_d;
      hold_q    <= hold_d;
      cycle_q   <= cycle_d;
      retired_q <= retired_d;
      cause_q   <= cause_d;
      pending_q <= pending_d;
      // Status outputs are decoded from the next state so they change on the
      // same edge as the state itself.
      dp_en_q   <= (state_d == S_RUN) || (state_d == S_HALTED);
      running_q <= (state_d == S_RUN);
      halted_q  <= (state_d == S_HALTED);
    end
  end

  assign bus.dp_en         = dp_en_q;
  assign bus.pc_write      = pc_write;
  assign bus.step_ack      = step_ack;
  assign bus.running       = running_q;
  assign bus.halted        = halted_q;
  assign bus.halt_cause    = cause_q;
  assign bus.cycle_count   = cycle_q;
  assign bus.retired_count = retired_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb_cpu_run_controller
//   Bench for cpu_run_controller. Two instances share one stimulus stream:
//   u_dut_a uses the default parameters, u_dut_b uses RESET_CYCLES=1 and
//   MAX_CYCLES=8 so that timeouts happen quickly.
module tb_cpu_run_controller;

  localparam logic [6:0]  HALT_OP   = 7'b1110011;
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] HALT_INSN = 32'h0000_0073;
  localparam logic [63:0] LIMIT     = 64'h400;

  typedef struct packed {
    logic        dp_en;
    logic        pc_write;
    logic        step_ack;
    logic        running;
    logic        halted;
    logic [1:0]  cause;
    logic [31:0] cyc;
    logic [31:0] ret;
  } outs_t;

  typedef struct {
    logic        start;
    logic        step_mode;
    logic        step_req;
    logic [31:0] instr;
    logic [63:0] pc;
    outs_t       exp;
  } vec_t;

  // Reference model: whether a run has been started, cycles of reset hold
  // still to go, whether it has stopped, and the architectural counters.
  typedef struct {
    bit          active;
    bit          stopped;
    bit          pending;
    int unsigned hold_left;
    logic [1:0]  cause;
    logic [31:0] cycles;
    logic [31:0] retired;
  } model_t;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  cpu_run_controller_if bus_a ();
  cpu_run_controller_if bus_b ();

  assign bus_b.start       = bus_a.start;
  assign bus_b.step_mode   = bus_a.step_mode;
  assign bus_b.step_req    = bus_a.step_req;
  assign bus_b.instruction = bus_a.instruction;
  assign bus_b.pc          = bus_a.pc;

  cpu_run_controller u_dut_a (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_a)
  );

  cpu_run_controller #(
    .RESET_CYCLES (1),
    .MAX_CYCLES   (32'd8)
  ) u_dut_b (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_b)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input outs_t act, input outs_t exp);
    check({tag, ".dp_en"},    act.dp_en,    exp.dp_en);
    check({tag, ".pc_write"}, act.pc_write, exp.pc_write);
    check({tag, ".step_ack"}, act.step_ack, exp.step_ack);
    check({tag, ".running"},  act.running,  exp.running);
    check({tag, ".halted"},   act.halted,   exp.halted);
    check({tag, ".cause"},    act.cause,    exp.cause);
    check({tag, ".cycles"},   act.cyc,      exp.cyc);
    check({tag, ".retired"},  act.ret,      exp.ret);
  endtask

  function automatic outs_t get_a();
    outs_t r;
    r.dp_en = bus_a.dp_en;     r.pc_write = bus_a.pc_write; r.step_ack = bus_a.step_ack;
    r.running = bus_a.running; r.halted = bus_a.halted;     r.cause = bus_a.halt_cause;
    r.cyc = bus_a.cycle_count; r.ret = bus_a.retired_count;
    return r;
  endfunction

  function automatic outs_t get_b();
    outs_t r;
    r.dp_en = bus_b.dp_en;     r.pc_write = bus_b.pc_write; r.step_ack = bus_b.step_ack;
    r.running = bus_b.running; r.halted = bus_b.halted;     r.cause = bus_b.halt_cause;
    r.cyc = bus_b.cycle_count; r.ret = bus_b.retired_count;
    return r;
  endfunction

  function automatic outs_t mk_out(input bit de, input bit pw, input bit ack, input bit run,
                                   input bit hlt, input logic [1:0] c, input int cy, input int rt);
    outs_t r;
    r.dp_en = de; r.pc_write = pw; r.step_ack = ack; r.running = run; r.halted = hlt;
    r.cause = c;  r.cyc = 32'(cy); r.ret = 32'(rt);
    return r;
  endfunction

  function automatic vec_t mk_vec(input bit st, input bit sm, input bit sr, input logic [31:0] ins,
                                  input logic [63:0] p, input outs_t e);
    vec_t v;
    v.start = st; v.step_mode = sm; v.step_req = sr; v.instr = ins; v.pc = p; v.exp = e;
    return v;
  endfunction

  function automatic model_t model_reset();
    model_t m;
    m.active = 0; m.stopped = 0; m.pending = 0; m.hold_left = 0;
    m.cause = 2'd0; m.cycles = 32'd0; m.retired = 32'd0;
    return m;
  endfunction

  function automatic outs_t model_out(input model_t m, input logic sm, input logic [31:0] ins,
                                      input logic [63:0] p);
    outs_t r;
    bit run;
    bit blocked;
    run     = m.active && !m.stopped && (m.hold_left == 0);
    blocked = (p >= LIMIT) || (ins[6:0] == HALT_OP);
    r.dp_en    = run || m.stopped;
    r.running  = run;
    r.halted   = m.stopped;
    r.pc_write = run && !blocked && (!sm || m.pending);
    r.step_ack = run && !blocked && m.pending;
    r.cause    = m.cause;
    r.cyc      = m.cycles;
    r.ret      = m.retired;
    return r;
  endfunction

  function automatic model_t model_next(input model_t m, input logic st, input logic sm,
                                        input logic sr, input logic [31:0] ins, input logic [63:0] p,
                                        input int unsigned rcyc, input logic [31:0] maxc);
    model_t n;
    outs_t  o;
    n = m;
    o = model_out(m, sm, ins, p);
    if (!m.active || m.stopped) begin
      if (st) begin
        n = model_reset();
        n.active    = 1;
        n.hold_left = rcyc;
      end
    end else if (m.hold_left != 0) begin
      n.hold_left = m.hold_left - 1;
    end else begin
      if (o.pc_write) n.retired = m.retired + 32'd1;
      if (p >= LIMIT)                  n.cause = 2'd3;
      else if (ins[6:0] == HALT_OP)    n.cause = 2'd1;
      else if (m.cycles == maxc - 32'd1) n.cause = 2'd2;
      if (n.cause != 2'd0) begin
        n.stopped = 1;
        n.pending = 0;
      end else begin
        n.cycles  = m.cycles + 32'd1;
        n.pending = o.step_ack ? 1'b0 : (m.pending || (sm && sr));
      end
    end
    return n;
  endfunction

  task automatic drive(input logic st, input logic sm, input logic sr, input logic [31:0] ins,
                       input logic [63:0] p);
    bus_a.start       = st;
    bus_a.step_mode   = sm;
    bus_a.step_req    = sr;
    bus_a.instruction = ins;
    bus_a.pc          = p;
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   vecs[11];
    outs_t  zero;
    model_t ma, mb;
    int     run_n, n_acks;
    logic   sm_r;

    zero = mk_out(0, 0, 0, 0, 0, 2'd0, 0, 0);

    // Start pulse, free run, halt opcode as the 5th instruction, then
    // requests in HALTED that must be ignored.
    vecs[0]  = mk_vec(1, 0, 0, NOP,       64'd0,  zero);
    vecs[1]  = mk_vec(0, 0, 0, NOP,       64'd0,  zero);
    vecs[2]  = mk_vec(0, 0, 0, NOP,       64'd0,  zero);
    vecs[3]  = mk_vec(0, 0, 0, NOP,       64'd0,  mk_out(1, 1, 0, 1, 0, 2'd0, 0, 0));
    vecs[4]  = mk_vec(0, 0, 0, NOP,       64'd4,  mk_out(1, 1, 0, 1, 0, 2'd0, 1, 1));
    vecs[5]  = mk_vec(0, 0, 0, NOP,       64'd8,  mk_out(1, 1, 0, 1, 0, 2'd0, 2, 2));
    vecs[6]  = mk_vec(0, 0, 0, NOP,       64'd12, mk_out(1, 1, 0, 1, 0, 2'd0, 3, 3));
    vecs[7]  = mk_vec(0, 0, 0, HALT_INSN, 64'd16, mk_out(1, 0, 0, 1, 0, 2'd0, 4, 4));
    vecs[8]  = mk_vec(0, 0, 0, NOP,       64'd16, mk_out(1, 0, 0, 0, 1, 2'd1, 4, 4));
    vecs[9]  = mk_vec(0, 1, 1, NOP,       64'd20, mk_out(1, 0, 0, 0, 1, 2'd1, 4, 4));
    vecs[10] = mk_vec(0, 0, 0, NOP,       64'd20, mk_out(1, 0, 0, 0, 1, 2'd1, 4, 4));

    // Power-on reset.
    Reset = 1'b1;
    drive(0, 0, 0, NOP, 64'd0);
    repeat (2) @(posedge Clk);
    #1;
    check_outs("por_a", get_a(), zero);
    check_outs("por_b", get_b(), zero);
    Reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].start, vecs[i].step_mode, vecs[i].step_req, vecs[i].instr, vecs[i].pc);
      @(negedge Clk);
      check_outs($sformatf("vec%0d", i), get_a(), vecs[i].exp);
      next_cycle();
    end

    // Restart from HALTED: counters and cause clear in RESET_HOLD.
    drive(1, 0, 0, NOP, 64'd0);
    @(negedge Clk);
    check_outs("restart_edge", get_a(), mk_out(1, 0, 0, 0, 1, 2'd1, 4, 4));
    next_cycle();
    for (int c = 0; c < 2; c++) begin
      drive(0, 0, 0, NOP, 64'd0);
      @(negedge Clk);
      check_outs($sformatf("restart_hold%0d", c), get_a(), zero);
      next_cycle();
    end
    for (int c = 0; c < 8; c++) begin
      drive(0, 0, 0, NOP, 64'(4 * c));
      @(negedge Clk);
      check_outs($sformatf("restart_run%0d", c), get_a(), mk_out(1, 1, 0, 1, 0, 2'd0, c, c));
      if (c != 7) next_cycle();
    end

    // Reset asserted mid-cycle with cycle_count=7: outputs clear at once.
    Reset = 1'b1;
    #1;
    check_outs("midreset_a", get_a(), zero);
    check_outs("midreset_b", get_b(), zero);
    next_cycle();
    check_outs("midreset_hold_a", get_a(), zero);
    Reset = 1'b0;

    // Timeout on the MAX_CYCLES=8 instance with only non-halt instructions.
    run_n = 0;
    for (int c = 0; c < 40; c++) begin
      drive(c == 0, 0, 0, NOP, 64'(4 * c));
      @(negedge Clk);
      if (bus_b.halted) break;
      if (bus_b.running) begin
        check($sformatf("timeout_pw%0d", run_n), bus_b.pc_write, 1'b1);
        run_n++;
      end
      next_cycle();
    end
    check("timeout_run_cycles", 64'(run_n), 64'd8);
    check_outs("timeout_end", get_b(), mk_out(1, 0, 0, 0, 1, 2'd2, 7, 8));
    next_cycle();

    // PC boundary on the default instance: just below the limit retires, at
    // the limit with a halt opcode the PC cause wins and nothing retires.
    drive(0, 0, 0, NOP, LIMIT - 64'd4);
    @(negedge Clk);
    check("pc_below_limit_pw", bus_a.pc_write, 1'b1);
    next_cycle();
    drive(0, 0, 0, HALT_INSN, LIMIT);
    @(negedge Clk);
    check("pc_limit_pw", bus_a.pc_write, 1'b0);
    check("pc_limit_ack", bus_a.step_ack, 1'b0);
    check("pc_limit_running", bus_a.running, 1'b1);
    next_cycle();
    drive(0, 0, 0, NOP, 64'd0);
    @(negedge Clk);
    check("pc_limit_halted", bus_a.halted, 1'b1);
    check("pc_limit_cause", bus_a.halt_cause, 2'd3);
    check("pc_limit_pw_after", bus_a.pc_write, 1'b0);
    next_cycle();

    // Step mode: a request during RESET_HOLD (ignored), then three requests
    // in RUN with the second one two cycles wide.
    Reset = 1'b1;
    next_cycle();
    Reset = 1'b0;
    n_acks = 0;
    for (int c = 0; c < 21; c++) begin
      int  r;
      bit  req;
      bit  exp_ack;
      r       = c - 3;
      req     = (c == 1) || (r == 2) || (r == 6) || (r == 7) || (r == 12);
      exp_ack = (r == 3) || (r == 7) || (r == 13);
      drive(c == 0, 1, req, NOP, 64'h100);
      @(negedge Clk);
      if (r >= 0) begin
        check($sformatf("step_ack_r%0d", r), bus_a.step_ack, exp_ack);
        check($sformatf("step_pw_r%0d", r), bus_a.pc_write, exp_ack);
        if (bus_a.step_ack) n_acks++;
      end else begin
        check($sformatf("step_hold_dp_en%0d", c), bus_a.dp_en, 1'b0);
      end
      next_cycle();
    end
    drive(0, 1, 0, NOP, 64'h100);
    @(negedge Clk);
    check("step_ack_total", 64'(n_acks), 64'd3);
    check("step_retired", bus_a.retired_count, 32'd3);
    check("step_running", bus_a.running, 1'b1);
    next_cycle();

    // Randomized run of both instances against the reference model.
    Reset = 1'b1;
    next_cycle();
    Reset = 1'b0;
    ma   = model_reset();
    mb   = model_reset();
    sm_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic        st, sr, rst;
      logic [31:0] ins;
      logic [63:0] p;
      int unsigned sel;
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) sm_r = ~sm_r;
      st  = ($urandom_range(0, 9) == 0);
      sr  = ($urandom_range(0, 2) == 0);
      ins = $urandom;
      if ($urandom_range(0, 19) == 0) ins[6:0] = HALT_OP;
      sel = $urandom_range(0, 49);
      if (sel == 0)      p = LIMIT + 64'($urandom_range(0, 7));
      else if (sel == 1) p = LIMIT - 64'd1;
      else               p = 64'($urandom_range(0, 32'h3ff));
      drive(st, sm_r, sr, ins, p);
      Reset = rst;
      if (rst) begin
        ma = model_reset();
        mb = model_reset();
      end
      @(negedge Clk);
      check_outs($sformatf("rand%0d_a", i), get_a(), model_out(ma, sm_r, ins, p));
      check_outs($sformatf("rand%0d_b", i), get_b(), model_out(mb, sm_r, ins, p));
      if (!rst) begin
        ma = model_next(ma, st, sm_r, sr, ins, p, 2, 32'd1024);
        mb = model_next(mb, st, sm_r, sr, ins, p, 1, 32'd8);
      end
      next_cycle();
    end
    Reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_run_controller.md
# cpu_run_controller

Run sequencer for the single-cycle CPU datapath. On a start request it holds the datapath in reset for a fixed number of cycles, then releases it and gates PC updates. Execution is either free-running or single-stepped. The block halts the CPU on a halt opcode, an out-of-range PC, or a cycle budget, and reports cycle and retired-instruction counts. It drives the `En` inputs of the PC register, register file and data memory, and the PC register's `Read` (write-enable) input.

## Interface
- `RESET_CYCLES`, default 2: cycles `dp_en` is held low after start (≥1).
- `MAX_CYCLES`, default 1024: RUN-cycle budget before timeout halt (1..2^32-1).
- `PC_LIMIT`, default 64'h400: first illegal PC byte address.
- `HALT_OPCODE`, default 7'b1110011: opcode that halts execution.

Ports:
- `Clk`  in  1  system clock, rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  run request, sampled each edge.
- `step_mode`  in  1  1 = single-step, 0 = free-run; sampled live.
- `step_req`  in  1  request to retire one instruction (step mode only).
- `instruction`  in  32  current instruction-memory output.
- `pc`  in  64  current PC register output.
- `dp_en`  out  1  datapath enable; 0 holds PC, register file and data memory in reset.
- `pc_write`  out  1  PC load enable; 1 = instruction retires this cycle.
- `step_ack`  out  1  pulses with each stepped retire.
- `running`  out  1  state is RUN.
- `halted`  out  1  state is HALTED.
- `halt_cause`  out  2  0 none, 1 halt opcode, 2 timeout, 3 PC out of range.
- `cycle_count`  out  32  cycles spent in RUN since last start.
- `retired_count`  out  32  cycles with `pc_write`=1 since last start.

## Operation
- States: IDLE, RESET_HOLD, RUN, HALTED.
- IDLE:
  - `dp_en`=0; `start`=1 → RESET_HOLD.
- RESET_HOLD:
  - `dp_en`=0; hold counter counts 0..RESET_CYCLES-1, then → RUN.
  - On entry, clear `cycle_count`, `retired_count`, `halt_cause` and `step_pending`.
- RUN:
  - `dp_en`=1. `cycle_count` increments every cycle.
  - `halt_hit`:
    - cause 3 if `pc` ≥ `PC_LIMIT`;
    - else cause 1 if `instruction[6:0]` == `HALT_OPCODE`;
    - else cause 2 if `cycle_count` == MAX_CYCLES-1.
  - `pc_write` (combinational) = RUN & !(cause 3 or 1 condition) & (!`step_mode` | `step_pending`).
  - Timeout does not block `pc_write`: the last budget cycle may retire.
  - `halt_hit` → HALTED at the next edge, latching `halt_cause`.
- HALTED:
  - `dp_en`=1 (state stays observable); `pc_write`=0; counters and cause frozen.
  - `start`=1 → RESET_HOLD (restart).
- `start` in RESET_HOLD or RUN is ignored.
- Step handshake:
  - A `step_req` sampled high in RUN with `step_mode`=1 sets `step_pending`.
  - While pending, `pc_write`=1 and `step_ack`=1 for one cycle, then pending clears.
  - `step_req` while pending is merged (not queued).
  - Pending clears on entering HALTED or RESET_HOLD.
  - If a halt opcode or out-of-range PC is present while pending, `pc_write` stays 0, `step_ack` stays 0 and the block halts.
- `retired_count` increments on each edge where `pc_write`=1.
- Switching `step_mode` 1→0 mid-run resumes free-run the same cycle. Switching 0→1 stops retiring the same cycle.
- Counters never wrap; `MAX_CYCLES` bounds `cycle_count`.

## Timing
- Reset (async) values: state IDLE, `dp_en`=0, `pc_write`=0, `step_ack`=0, `running`=0, `halted`=0, `halt_cause`=0, both counters 0, `step_pending`=0. `Reset` mid-run aborts immediately to these values.
- `start` sampled high at edge E0 → RESET_HOLD during cycles 1..`RESET_CYCLES` → RUN from cycle `RESET_CYCLES`+1.
- With `RESET_CYCLES`=2 and free-run, the first `pc_write`=1 is in cycle 3.
- `pc_write` and `step_ack` are combinational from state, `step_pending`, `step_mode`, `instruction` and `pc`. All other outputs are registered.
- Step latency: `step_req` at edge En → `pc_write`/`step_ack` high in the cycle after En → PC updates at edge En+1.
- Halt latency: the condition is visible in cycle k → `halted`=1 from edge k+1.
- Free-run timeout with `MAX_CYCLES`=N:
  - RUN lasts exactly N cycles; `cycle_count` ends at N-1, then freezes.
  - `retired_count`=N when no other halt occurs.

## Test plan
- Reset mid-RUN with `cycle_count`=7 → all outputs return to reset values at once; `dp_en`=0.
- Start pulse, `RESET_CYCLES`=2, free-run, halt opcode at the 5th instruction:
  - `dp_en` low for 2 cycles after the start edge.
  - `retired_count`=4, `halt_cause`=1, `halted`=1.
- `MAX_CYCLES`=8 with only non-halt instructions → `halt_cause`=2, `cycle_count`=7, `retired_count`=8.
- `pc` driven to `PC_LIMIT` while `instruction` also holds `HALT_OPCODE` → `halt_cause`=3 (priority), `pc_write`=0 that cycle.
- Step mode, three `step_req` pulses with a double-wide second pulse:
  - exactly 3 `step_ack` pulses, `retired_count`=3;
  - `pc_write` never high without a prior request.
- From HALTED, assert `start` → counters and cause clear in RESET_HOLD; RUN resumes after `RESET_CYCLES`.
